aes128_iter_ctrl: RTL and testbench
===================================

# aes128_iter_ctrl

Iterative AES-128 encryption engine: a controller that sequences one full AES round per clock through the SubBytes, ShiftRows, MixColumns and AddRoundKey stages, with on-the-fly key expansion. It sits between the host-facing block interface and the round-function datapath. It owns the state register, the round-key register, the round counter and the valid/ready handshakes on both sides.

## Interface
- NUM_ROUNDS, 10: number of rounds. The legal range is 1–10. Only 10 is FIPS-197 AES-128; values below 10 are reduced-round, for debug only. The final round (round == NUM_ROUNDS) omits MixColumns.
- clk  in  1  the single clock. All flops are rising-edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  pt/key are valid.
- in_ready  out  1  high only in IDLE. A block is accepted on a rising edge where in_valid && in_ready.
- pt  in  128  plaintext. Bits [127:120] are byte 0. Layout is column-major: bits [127:96] are column 0.
- key  in  128  cipher key, same byte layout as pt. Sampled only at acceptance.
- out_valid  out  1  ct is valid.
- out_ready  in  1  the consumer accepts ct. Handshake completes on a rising edge where out_valid && out_ready.
- ct  out  128  ciphertext.
- busy  out  1  high in RUN or DONE.
- round  out  4  current round index. 0 in IDLE, 1..NUM_ROUNDS in RUN, NUM_ROUNDS in DONE.

## Operation
The controller has three states: IDLE, RUN and DONE.

**IDLE**
- On accept: st ← pt ^ key, rk ← key, round ← 1, go to RUN.
- Otherwise hold.

**RUN** (one round per cycle)
- nk = ExpandKey(rk, rcon[round]):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon, where w0 = rk[127:96] and w3 = rk[31:0].
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - RotWord moves the top byte to the bottom. SubWord uses four byte S-boxes.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. It occupies the top byte of a word; the other three bytes are zero.
- st ← AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), nk). MixColumns is bypassed when round == NUM_ROUNDS.
- rk ← nk.
- If round == NUM_ROUNDS: go to DONE and hold round. Otherwise round ← round + 1.

**DONE**
- out_valid = 1 and ct = st.
- On the output handshake, go to IDLE and set round ← 0.

**Datapath rules**
- MixColumns is GF(2^8) arithmetic, not integer arithmetic:
  - ×2 = xtime (shift left 1, XOR 0x1B if bit 7 was set).
  - ×3 = xtime(a) ^ a.
  - All sums are XOR.
- The FIPS-197 vectors are the acceptance criterion for the whole datapath.

**Other behaviour**
- in_valid is ignored outside IDLE. pt and key may change freely after acceptance.
- ct and out_valid hold stable while out_valid && !out_ready.
- ct is driven from a register, with no combinational path from inputs.

## Timing
**Reset values:** state = IDLE, in_ready = 1, out_valid = 0, busy = 0, round = 0, ct = 0, st = 0, rk = 0.

**Reset during operation:** rst high at any edge, in any state, aborts the operation. The block is in IDLE with the reset values on the next cycle, and the partial result is discarded. rst overrides simultaneous in_valid and out_ready.

**Latency (NUM_ROUNDS = 10):**
- Accept at edge T.
- RUN occupies edges T+1 .. T+10.
- out_valid is high from the cycle after edge T+10.

**Throughput:**
- The output handshake at edge T+11 returns the block to IDLE.
- The next accept can happen at edge T+12, giving a minimum period of 12 cycles per block.
- Each extra cycle out_ready stays low adds 1 cycle.

**Simultaneous events:**
- in_valid during DONE is not accepted, even when out_ready is high. It is accepted on the following cycle in IDLE.

**Per-cycle ordering:** combinational paths per cycle are
- S-box → ShiftRows → MixColumns → XOR, and
- S-box → key XOR chain.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready = 1 → ct 3925841d02dc09fbdc118597196a0b32, with out_valid rising exactly 11 cycles after accept and round stepping 1..10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a. Also key = 0, pt = 0 → ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-pressure: App. B vector with out_ready held low for 5 cycles after out_valid → ct and out_valid stable, in_ready = 0 throughout, and IDLE is reached one cycle after out_ready rises.
- Back-to-back: in_valid and out_ready held high while alternating the App. B and App. C.1 vectors → accepts spaced exactly 12 cycles apart, and both ciphertexts are correct in order. in_valid pulses while busy are ignored: ct unaffected and no extra output.
- Reset mid-operation: assert rst for 1 cycle while round = 5 → next cycle in_ready = 1, out_valid = 0, busy = 0, round = 0, ct = 0. A following App. C.1 block then produces the correct ct with nominal latency.
- Reduced rounds: NUM_ROUNDS = 1, key = 0, pt = 0 → ct = 0x63 repeated 16 times XOR round-1 key 62636363626363636263636362636363, giving 01000000010000000100000001000000, with out_valid 2 cycles after accept.

Source files
------------

// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl: iterative AES-128 encryptor, one full round per clock with on-the-fly key expansion.
// Owns the state, round-key and round-counter registers and both valid/ready handshakes.
module aes128_iter_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy,
    output logic [3:0]   round
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    // Byte 0x00 lives in the top byte so the table reads like the FIPS-197 figure.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes fused with ShiftRows: row k of column c comes from column (c+k)%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[127-8*(4*c+k) -: 8] = sbox(s[127-8*(4*((c+k)%4)+k) -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        return {xtime(c[31:24]) ^ xtime(c[23:16]) ^ c[23:16] ^ c[15:8] ^ c[7:0],
                c[31:24] ^ xtime(c[23:16]) ^ xtime(c[15:8]) ^ c[15:8] ^ c[7:0],
                c[31:24] ^ c[23:16] ^ xtime(c[15:8]) ^ xtime(c[7:0]) ^ c[7:0],
                xtime(c[31:24]) ^ c[31:24] ^ c[23:16] ^ c[15:8] ^ xtime(c[7:0])};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d, rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  t, w0, w1, w2, w3;
    logic [127:0] nk, ss, mc;
    logic         last;

    assign t    = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon_q, 24'h0};
    assign w0   = rk_q[127:96] ^ t;
    assign w1   = rk_q[95:64] ^ w0;
    assign w2   = rk_q[63:32] ^ w1;
    assign w3   = rk_q[31:0] ^ w2;
    assign nk   = {w0, w1, w2, w3};
    assign ss   = sub_shift(st_q);
    assign mc   = {mix_col(ss[127:96]), mix_col(ss[95:64]), mix_col(ss[63:32]), mix_col(ss[31:0])};
    assign last = round_q == LAST;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                st_d    = pt ^ key;
                rk_d    = key;
                round_d = 4'd1;
                rcon_d  = 8'h01;
            end
            RUN: begin
                st_d    = (last ? ss : mc) ^ nk;
                rk_d    = nk;
                rcon_d  = xtime(rcon_q);
                state_d = last ? DONE : RUN;
                round_d = last ? round_q : round_q + 4'd1;
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                round_d = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign round     = round_q;
    assign ct        = st_q;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// tb_aes128_iter_ctrl: FIPS-197 vectors, random blocks against a textbook AES model, and handshake corner cases.
module tb_aes128_iter_ctrl;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 0, rst = 1, in_valid = 0, in_valid1 = 0, out_ready = 1;
    logic [127:0] pt = '0, key = '0;
    logic in_ready, out_valid, busy, in_ready1, out_valid1, busy1;
    logic [127:0] ct, ct1;
    logic [3:0] round, round1;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] sb [256];
    vec_t vecs [9];

    always #5 clk = ~clk;

    aes128_iter_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .busy(busy), .round(round)
    );

    aes128_iter_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .pt(pt), .key(key),
        .out_valid(out_valid1), .out_ready(out_ready), .ct(ct1), .busy(busy1), .round(round1)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        logic [31:0] tw;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[q+4*c] = (rd == 10 ? t[q+4*c] :
                                gmul(8'h02, t[q+4*c]) ^ gmul(8'h03, t[(q+1)%4+4*c]) ^
                                t[(q+2)%4+4*c] ^ t[(q+3)%4+4*c]) ^ w[4*rd+c][31-8*q -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_out(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'd10);
    endtask

    task automatic run_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        key = k;
        pt = p;
        in_valid = 1;
        tick();
        in_valid = 0;
        key = rnd128();
        pt = rnd128();
        wait_out(name);
        chk({name, " ct"}, ct, e);
        out_ready = 1;
        tick();
        chk({name, " idle after handshake"}, 128'({in_ready, out_valid, busy, round}), 128'({3'b100, 4'd0}));
    endtask

    initial begin
        int nacc, nout, n;
        int acc [3];
        build_sbox();
        vecs[0] = '{KB, PB, CB};
        vecs[1] = '{KC, PC, CC};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        for (int i = 3; i < 9; i++) begin
            vecs[i].key = rnd128();
            vecs[i].pt = rnd128();
            vecs[i].ct = aes_ref(vecs[i].key, vecs[i].pt);
        end

        // Reset wins over a simultaneous in_valid.
        rst = 1;
        in_valid = 1;
        tick();
        tick();
        chk("reset flags", 128'({in_ready, out_valid, busy, round}), 128'({3'b100, 4'd0}));
        chk("reset ct", ct, 128'h0);
        rst = 0;
        in_valid = 0;
        tick();
        chk("idle holds", 128'({in_ready, busy}), 128'(2'b10));

        // App. B with round-by-round stepping.
        key = KB;
        pt = PB;
        in_valid = 1;
        tick();
        in_valid = 0;
        pt = rnd128();
        key = rnd128();
        chk("appB busy", 128'({in_ready, busy}), 128'(2'b01));
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("appB round %0d", k), 128'({out_valid, round}), 128'({1'b0, 4'(k)}));
            tick();
        end
        chk("appB done", 128'({out_valid, round, busy}), 128'({1'b1, 4'd10, 1'b1}));
        chk("appB ct", ct, CB);
        tick();
        chk("appB idle", 128'({in_ready, out_valid, round}), 128'({2'b10, 4'd0}));

        for (int i = 0; i < 9; i++) run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("vec%0d", i));

        // Back-pressure, then an in_valid that is already high while DONE is left.
        out_ready = 0;
        key = KB;
        pt = PB;
        in_valid = 1;
        tick();
        in_valid = 0;
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp ct hold", ct, CB);
            chk("bp flags hold", 128'({in_ready, out_valid}), 128'(2'b01));
            in_valid = 1;
            key = KC;
            pt = PC;
            tick();
        end
        out_ready = 1;
        tick();
        chk("bp idle after release", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        tick();
        in_valid = 0;
        chk("accept after done", 128'({busy, round}), 128'({1'b1, 4'd1}));
        wait_out("bp next");
        chk("bp next ct", ct, CC);
        tick();

        // Back-to-back with in_valid held high.
        nacc = 0;
        nout = 0;
        in_valid = 1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid) begin
                chk($sformatf("b2b ct %0d", nout), ct, (nout % 2) ? CC : CB);
                nout++;
            end
            if (in_ready) begin
                if (nacc < 3) begin
                    key = (nacc % 2) ? KC : KB;
                    pt = (nacc % 2) ? PC : PB;
                    acc[nacc] = cyc;
                    nacc++;
                end else in_valid = 0;
            end
            tick();
        end
        in_valid = 0;
        chk("b2b outputs", 128'(nout), 128'd3);
        chk("b2b spacing 1", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b spacing 2", 128'(acc[2] - acc[1]), 128'd12);

        // Reset in the middle of a block.
        key = KC;
        pt = PC;
        in_valid = 1;
        tick();
        in_valid = 0;
        n = 0;
        while (round != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("reached round 5", 128'(round), 128'd5);
        rst = 1;
        in_valid = 1;
        tick();
        rst = 0;
        in_valid = 0;
        chk("midrst flags", 128'({in_ready, out_valid, busy, round}), 128'({3'b100, 4'd0}));
        chk("midrst ct", ct, 128'h0);
        run_block(KC, PC, CC, "post reset");

        // Single-round instance.
        key = '0;
        pt = '0;
        in_valid1 = 1;
        tick();
        in_valid1 = 0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        chk("nr1 latency", 128'(n), 128'd1);
        chk("nr1 ct", ct1, 128'h01000000010000000100000001000000);
        tick();
        chk("nr1 idle", 128'({in_ready1, out_valid1, busy1, round1}), 128'({3'b100, 4'd0}));
        chk("main idle", 128'({in_ready, out_valid}), 128'(2'b10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
